// File: rtl/execution_unit.sv
// MIPS32 EX stage: ALU, JAL link address and destination select, with an EX/MEM register.
// Optional feature macro: EXU_MUL_EN (adds a single-cycle signed multiply on op 15).
module execution_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ID_EX_rs_val,
    input  logic [31:0] ID_EX_rt_val,
    input  logic [31:0] ID_EX_ext_imm,
    input  logic [4:0]  ID_EX_shamt,
    input  logic [4:0]  ID_EX_rt,
    input  logic [4:0]  ID_EX_rd,
    input  logic [3:0]  ID_EX_ALUControl,
    input  logic        ID_EX_R,
    input  logic        ID_EX_JALControl,
    input  logic [31:0] ID_EX_PC4,
    input  logic        ID_EX_RegWrite,
    output logic [31:0] EX_ALUResult,
    output logic [4:0]  EX_WriteRegister,
    output logic [31:0] EX_MEM_ALUResult,
    output logic [4:0]  EX_MEM_WriteRegister,
    output logic        EX_MEM_RegWrite
);

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_XOR  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_SLLV = 4'd11,
        OP_SRLV = 4'd12,
        OP_SRAV = 4'd13,
        OP_LUI  = 4'd14,
        OP_MUL  = 4'd15
    } alu_op_e;

    localparam logic [4:0] LINK_REG = 5'd31;

    alu_op_e     alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shift_amt;
    logic [31:0] shift_res;
    logic [31:0] mul_res;
    logic [31:0] alu_res;

    logic [31:0] alu_result_d, alu_result_q;
    logic [4:0]  write_reg_d,  write_reg_q;
    logic        reg_write_d,  reg_write_q;

    assign alu_op = alu_op_e'(ID_EX_ALUControl);
    assign op_a   = ID_EX_rs_val;
    assign op_b   = ID_EX_R ? ID_EX_rt_val : ID_EX_ext_imm;

`ifdef EXU_MUL_EN
    // A 32-bit-wide signed product keeps only the low word, which is all MUL returns.
    logic signed [31:0] mul_prod;
    assign mul_prod = $signed(op_a) * $signed(op_b);
    assign mul_res  = mul_prod;
`else
    assign mul_res  = 32'h0;
`endif

    // Fixed-amount and variable shifts share one shifter; only the amount source differs.
    always_comb begin
        shift_amt = ID_EX_shamt;
        if ((alu_op == OP_SLLV) || (alu_op == OP_SRLV) || (alu_op == OP_SRAV)) begin
            shift_amt = op_a[4:0];
        end
        shift_res = '0;
        unique case (alu_op)
            OP_SLL, OP_SLLV: shift_res = op_b << shift_amt;
            OP_SRL, OP_SRLV: shift_res = op_b >> shift_amt;
            OP_SRA, OP_SRAV: shift_res = $unsigned($signed(op_b) >>> shift_amt);
            default:         shift_res = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {31'b0, (op_a < op_b)};
            OP_SLL, OP_SRL, OP_SRA,
            OP_SLLV, OP_SRLV, OP_SRAV:
                     alu_res = shift_res;
            OP_LUI:  alu_res = {op_b[15:0], 16'h0};
            OP_MUL:  alu_res = mul_res;
            default: alu_res = '0;
        endcase
    end

    // The delay slot executes, so the link address skips it: PC+4 of this instruction, plus 4.
    always_comb begin
        alu_result_d = alu_res;
        write_reg_d  = ID_EX_R ? ID_EX_rd : ID_EX_rt;
        if (ID_EX_JALControl) begin
            alu_result_d = ID_EX_PC4 + 32'd4;
            write_reg_d  = LINK_REG;
        end
        reg_write_d = ID_EX_RegWrite && (write_reg_d != 5'd0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            alu_result_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign EX_ALUResult         = alu_result_d;
    assign EX_WriteRegister     = write_reg_d;
    assign EX_MEM_ALUResult     = alu_result_q;
    assign EX_MEM_WriteRegister = write_reg_q;
    assign EX_MEM_RegWrite      = reg_write_q;

endmodule

// File: tb/tb_execution_unit.sv
// Scoreboard bench for execution_unit: directed vectors, expected EX/MEM values queued per issue.
module tb_execution_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] ID_EX_rs_val;
    logic [31:0] ID_EX_rt_val;
    logic [31:0] ID_EX_ext_imm;
    logic [4:0]  ID_EX_shamt;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rd;
    logic [3:0]  ID_EX_ALUControl;
    logic        ID_EX_R;
    logic        ID_EX_JALControl;
    logic [31:0] ID_EX_PC4;
    logic        ID_EX_RegWrite;
    logic [31:0] EX_ALUResult;
    logic [4:0]  EX_WriteRegister;
    logic [31:0] EX_MEM_ALUResult;
    logic [4:0]  EX_MEM_WriteRegister;
    logic        EX_MEM_RegWrite;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wreg;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

`ifdef EXU_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'hFFFFFFEB;
`else
    localparam logic [31:0] MUL_EXP = 32'h0;
`endif

    execution_unit dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .ID_EX_rs_val         (ID_EX_rs_val),
        .ID_EX_rt_val         (ID_EX_rt_val),
        .ID_EX_ext_imm        (ID_EX_ext_imm),
        .ID_EX_shamt          (ID_EX_shamt),
        .ID_EX_rt             (ID_EX_rt),
        .ID_EX_rd             (ID_EX_rd),
        .ID_EX_ALUControl     (ID_EX_ALUControl),
        .ID_EX_R              (ID_EX_R),
        .ID_EX_JALControl     (ID_EX_JALControl),
        .ID_EX_PC4            (ID_EX_PC4),
        .ID_EX_RegWrite       (ID_EX_RegWrite),
        .EX_ALUResult         (EX_ALUResult),
        .EX_WriteRegister     (EX_WriteRegister),
        .EX_MEM_ALUResult     (EX_MEM_ALUResult),
        .EX_MEM_WriteRegister (EX_MEM_WriteRegister),
        .EX_MEM_RegWrite      (EX_MEM_RegWrite)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: registered outputs are presented every cycle; one queued entry per issued vector.
    always @(posedge Clk) begin
        #1;
        if (Reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check32("mem_result", EX_MEM_ALUResult, e.res);
            check32("mem_wreg", {27'b0, EX_MEM_WriteRegister}, {27'b0, e.wreg});
            check32("mem_regwrite", {31'b0, EX_MEM_RegWrite}, {31'b0, e.rw});
        end
    end

    // Applies a vector just after a falling edge, checks the combinational outputs, queues the rest.
    task automatic issue(input string name, input logic [3:0] op, input logic r,
                         input logic [31:0] rs, input logic [31:0] rtv, input logic [31:0] imm,
                         input logic [4:0] sh, input logic [4:0] rt, input logic [4:0] rd,
                         input logic jal, input logic [31:0] pc4, input logic rw,
                         input logic [31:0] exp_res, input logic [4:0] exp_wreg, input logic exp_rw);
        exp_t e;
        @(negedge Clk);
        ID_EX_ALUControl = op;
        ID_EX_R          = r;
        ID_EX_rs_val     = rs;
        ID_EX_rt_val     = rtv;
        ID_EX_ext_imm    = imm;
        ID_EX_shamt      = sh;
        ID_EX_rt         = rt;
        ID_EX_rd         = rd;
        ID_EX_JALControl = jal;
        ID_EX_PC4        = pc4;
        ID_EX_RegWrite   = rw;
        #1;
        check32({name, "_comb_res"}, EX_ALUResult, exp_res);
        check32({name, "_comb_wreg"}, {27'b0, EX_WriteRegister}, {27'b0, exp_wreg});
        e.res  = exp_res;
        e.wreg = exp_wreg;
        e.rw   = exp_rw;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset = 1'b0;
        ID_EX_rs_val = '0; ID_EX_rt_val = '0; ID_EX_ext_imm = '0; ID_EX_shamt = '0;
        ID_EX_rt = '0; ID_EX_rd = '0; ID_EX_ALUControl = '0; ID_EX_R = 1'b0;
        ID_EX_JALControl = 1'b0; ID_EX_PC4 = '0; ID_EX_RegWrite = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        check32("rst_result", EX_MEM_ALUResult, 32'h0);
        check32("rst_wreg", {27'b0, EX_MEM_WriteRegister}, 32'h0);
        check32("rst_regwrite", {31'b0, EX_MEM_RegWrite}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        //      name     op     R     rs            rt_val        imm           sh    rt    rd    jal   pc4           rw    exp_res       wreg  rw
        issue("add_i",  4'd2,  1'b0, 32'd5,        32'h0,        32'hFFFFFFFD, 5'd0, 5'd9, 5'd3, 1'b0, 32'h0,        1'b1, 32'd2,        5'd9, 1'b1);
        issue("slt",    4'd6,  1'b1, 32'hFFFFFFFF, 32'd1,        32'h0,        5'd0, 5'd2, 5'd4, 1'b0, 32'h0,        1'b1, 32'd1,        5'd4, 1'b1);
        issue("sltu",   4'd7,  1'b1, 32'hFFFFFFFF, 32'd1,        32'h0,        5'd0, 5'd2, 5'd4, 1'b0, 32'h0,        1'b1, 32'd0,        5'd4, 1'b1);
        issue("srl",    4'd9,  1'b1, 32'h0,        32'h80000000, 32'h0,        5'd4, 5'd2, 5'd5, 1'b0, 32'h0,        1'b1, 32'h08000000, 5'd5, 1'b1);
        issue("sra",    4'd10, 1'b1, 32'h0,        32'h80000000, 32'h0,        5'd4, 5'd2, 5'd5, 1'b0, 32'h0,        1'b1, 32'hF8000000, 5'd5, 1'b1);
        issue("sllv",   4'd11, 1'b1, 32'd33,       32'd3,        32'h0,        5'd7, 5'd2, 5'd6, 1'b0, 32'h0,        1'b1, 32'd6,        5'd6, 1'b1);
        issue("srlv",   4'd12, 1'b1, 32'd36,       32'h80000000, 32'h0,        5'd0, 5'd2, 5'd6, 1'b0, 32'h0,        1'b1, 32'h08000000, 5'd6, 1'b1);
        issue("srav",   4'd13, 1'b1, 32'd4,        32'h80000000, 32'h0,        5'd0, 5'd2, 5'd6, 1'b0, 32'h0,        1'b1, 32'hF8000000, 5'd6, 1'b1);
        issue("jal",    4'd2,  1'b1, 32'd1,        32'd1,        32'h0,        5'd0, 5'd2, 5'd7, 1'b1, 32'h00400010, 1'b1, 32'h00400014, 5'd31, 1'b1);
        issue("zero",   4'd1,  1'b1, 32'hF0,       32'h0F,       32'h0,        5'd0, 5'd2, 5'd0, 1'b0, 32'h0,        1'b1, 32'hFF,       5'd0, 1'b0);
        issue("mul",    4'd15, 1'b1, 32'hFFFFFFFD, 32'd7,        32'h0,        5'd0, 5'd2, 5'd8, 1'b0, 32'h0,        1'b1, MUL_EXP,      5'd8, 1'b1);
        issue("and",    4'd0,  1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        5'd0, 5'd2, 5'd8, 1'b0, 32'h0,        1'b1, 32'h0F000F00, 5'd8, 1'b1);
        issue("xor",    4'd3,  1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        5'd0, 5'd2, 5'd8, 1'b0, 32'h0,        1'b1, 32'hF00FF00F, 5'd8, 1'b1);
        issue("nor",    4'd4,  1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        5'd0, 5'd2, 5'd8, 1'b0, 32'h0,        1'b1, 32'h00F000F0, 5'd8, 1'b1);
        issue("sub",    4'd5,  1'b1, 32'd0,        32'd1,        32'h0,        5'd0, 5'd2, 5'd9, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 5'd9, 1'b1);
        issue("sll0",   4'd8,  1'b1, 32'h0,        32'h12345678, 32'h0,        5'd0, 5'd2, 5'd9, 1'b0, 32'h0,        1'b1, 32'h12345678, 5'd9, 1'b1);
        issue("lui",    4'd14, 1'b0, 32'h0,        32'h0,        32'h0000ABCD, 5'd0, 5'd10, 5'd3, 1'b0, 32'h0,       1'b1, 32'hABCD0000, 5'd10, 1'b1);
        issue("addovf", 4'd2,  1'b1, 32'h7FFFFFFF, 32'd1,        32'h0,        5'd0, 5'd2, 5'd11, 1'b0, 32'h0,       1'b0, 32'h80000000, 5'd11, 1'b0);

        // Asynchronous reset between edges: registered outputs must clear without a clock.
        issue("pre_rst", 4'd1, 1'b1, 32'h55,       32'hAA,       32'h0,        5'd0, 5'd2, 5'd12, 1'b0, 32'h0,       1'b1, 32'hFF,       5'd12, 1'b1);
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        check32("async_result", EX_MEM_ALUResult, 32'h0);
        check32("async_wreg", {27'b0, EX_MEM_WriteRegister}, 32'h0);
        check32("async_regwrite", {31'b0, EX_MEM_RegWrite}, 32'h0);
        @(posedge Clk);
        #2;
        check32("hold_result", EX_MEM_ALUResult, 32'h0);
        check32("hold_regwrite", {31'b0, EX_MEM_RegWrite}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        issue("post_rst", 4'd2, 1'b1, 32'd10,      32'd20,       32'h0,        5'd0, 5'd2, 5'd13, 1'b0, 32'h0,       1'b1, 32'd30,       5'd13, 1'b1);

        repeat (3) @(posedge Clk);
        #2;
        check32("queue_drained", exp_q.size(), 32'd0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: got no completion, expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
